// File: rtl/seg_scan_ctl.sv
`timescale 1ns/1ps
// seg_scan_ctl: time-multiplexed seven-segment display scanner.
// Shows NDIGITS hex digits on a shared active-low segment bus with one-hot
// active-low anodes. A free-running prescaler sets the slot length
// (2**DIV_BITS cycles per digit). Optional PWM dimming is compiled in with
// the macro SEG_SCAN_DIM_EN; without it bright_i is ignored.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     synchronous active-high reset
//   enb_i     global display enable (0 blanks all digits, scan continues)
//   data_i    packed hex nibbles, digit i = data_i[4*i+3:4*i]
//   dp_i      decimal point request per digit, active-high
//   mask_i    per-digit enable, 0 blanks that digit's slot
//   bright_i  brightness 0..15 (dimming build only)
//   an_o      anodes, active-low, at most one bit low
//   seg_o     segments {g,f,e,d,c,b,a}, active-low
//   dp_n_o    decimal point, active-low
//   digit_o   index of the digit currently scanned
//   frame_o   one-cycle pulse when an_o first shows digit 0 after a wrap
module seg_scan_ctl #(
  parameter int unsigned NDIGITS  = 8,
  parameter int unsigned DIV_BITS = 17,
  localparam int unsigned DW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enb_i,
  input  logic [4*NDIGITS-1:0]   data_i,
  input  logic [NDIGITS-1:0]     dp_i,
  input  logic [NDIGITS-1:0]     mask_i,
  input  logic [3:0]             bright_i,
  output logic [NDIGITS-1:0]     an_o,
  output logic [6:0]             seg_o,
  output logic                   dp_n_o,
  output logic [DW-1:0]          digit_o,
  output logic                   frame_o
);

  localparam logic [DW-1:0] LAST_DIGIT = DW'(NDIGITS - 1);

  logic [DIV_BITS-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic                wrap_q, wrap_d;
  logic [NDIGITS-1:0]  an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic                frame_q, frame_d;

  logic [3:0]          nib;
  logic                dp_sel;
  logic                mask_sel;
  logic                dim_open;
  logic                lit;
  logic [6:0]          hex7;

  // Prescaler and digit counter; wrap_d marks the edge that returns to digit 0.
  always_comb begin
    pcnt_d  = pcnt_q + DIV_BITS'(1);
    digit_d = digit_q;
    wrap_d  = 1'b0;
    if (&pcnt_q) begin
      if (digit_q == LAST_DIGIT) begin
        digit_d = '0;
        wrap_d  = 1'b1;
      end else begin
        digit_d = digit_q + DW'(1);
      end
    end
  end

  // Select the current digit's nibble, dp request and mask bit.
  always_comb begin
    nib      = 4'h0;
    dp_sel   = 1'b0;
    mask_sel = 1'b0;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (digit_q == DW'(i)) begin
        nib      = data_i[4*i +: 4];
        dp_sel   = dp_i[i];
        mask_sel = mask_i[i];
      end
    end
  end

`ifdef SEG_SCAN_DIM_EN
  // PWM gate: lit while the top prescaler nibble is within the brightness level.
  assign dim_open = (pcnt_q[DIV_BITS-1 -: 4] <= bright_i);
`else
  logic unused_bright;
  assign unused_bright = ^bright_i;
  assign dim_open      = 1'b1;
`endif

  // Hex to active-low gfedcba.
  always_comb begin
    hex7 = 7'h7F;
    case (nib)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
      default: hex7 = 7'h7F;
    endcase
  end

  // Next output values; unlit slots drive everything inactive.
  always_comb begin
    lit     = enb_i & mask_sel & dim_open;
    an_d    = '1;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      an_d[i] = ~(lit && (digit_q == DW'(i)));
    end
    seg_d   = lit ? hex7 : 7'h7F;
    dp_n_d  = ~(lit & dp_sel);
    frame_d = wrap_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q  <= '0;
      digit_q <= '0;
      wrap_q  <= 1'b0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_n_q  <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      digit_q <= digit_d;
      wrap_q  <= wrap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_n_q  <= dp_n_d;
      frame_q <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_n_o  = dp_n_q;
  assign digit_o = digit_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctl.sv
`timescale 1ns/1ps
// Testbench for seg_scan_ctl (NDIGITS=4, DIV_BITS=4, 16-cycle slots).
module tb_seg_scan_ctl;

  localparam int NDIG = 4;
  localparam int SLOT = 16;
  localparam int FRAME = NDIG * SLOT;

  logic        clk = 1'b0;
  logic        rst_i, enb_i;
  logic [15:0] data_i;
  logic [3:0]  dp_i, mask_i, bright_i;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_n_o;
  logic [1:0]  digit_o;
  logic        frame_o;

  seg_scan_ctl #(.NDIGITS(NDIG), .DIV_BITS(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .enb_i(enb_i), .data_i(data_i), .dp_i(dp_i),
    .mask_i(mask_i), .bright_i(bright_i), .an_o(an_o), .seg_o(seg_o),
    .dp_n_o(dp_n_o), .digit_o(digit_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       frame;
    logic [1:0] digit;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic        enb;
    logic [3:0]  bright;
    logic [27:0] segs;   // expected lit segments {d3,d2,d1,d0}
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  logic [27:0] exp_segs;
  int          cyc   = 0;
  int          n     = 0;   // cycles since the last reset edge
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard checker: compare the entry due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      tests++;
      if ({an_o, seg_o, dp_n_o, frame_o, digit_o} !== {e.an, e.seg, e.dp_n, e.frame, e.digit}
          || !$onehot0(~an_o)) begin
        fails++;
        $display("FAIL scan cyc=%0d: got an=%b seg=%b dp_n=%b frame=%b digit=%0d, want an=%b seg=%b dp_n=%b frame=%b digit=%0d",
                 cyc, an_o, seg_o, dp_n_o, frame_o, digit_o, e.an, e.seg, e.dp_n, e.frame, e.digit);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  // Drive one cycle and push the outputs expected after the next edge.
  task automatic drive(input bit do_rst);
    exp_t e;
    int   d;
    logic gate;
    logic lit;
    rst_i = do_rst;
    e.due = cyc + 1;
    if (do_rst) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1; e.frame = 1'b0; e.digit = 2'd0;
    end else begin
      d = (n / SLOT) % NDIG;
`ifdef SEG_SCAN_DIM_EN
      gate = ((n % SLOT) <= int'(bright_i));
`else
      gate = 1'b1;
`endif
      lit     = enb_i && mask_i[d] && gate;
      e.an    = lit ? ~(4'b0001 << d) : 4'hF;
      e.seg   = lit ? exp_segs[7*d +: 7] : 7'h7F;
      e.dp_n  = lit ? ~dp_i[d] : 1'b1;
      e.frame = (n % FRAME == 0) && (n > 0);
      e.digit = 2'(((n + 1) / SLOT) % NDIG);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    n = do_rst ? 0 : n + 1;
  endtask

  task automatic apply(input vec_t v);
    data_i = v.data; dp_i = v.dp; mask_i = v.mask;
    enb_i = v.enb; bright_i = v.bright; exp_segs = v.segs;
  endtask

  initial begin
    int k;
    vecs[0] = '{16'h3210, 4'b0000, 4'hF,    1'b1, 4'hF,
                {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}};
    vecs[1] = '{16'h7654, 4'b0001, 4'hF,    1'b1, 4'hF,
                {7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001}};
    vecs[2] = '{16'hBA98, 4'b1001, 4'hF,    1'b1, 4'hF,
                {7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000}};
    vecs[3] = '{16'hFEDC, 4'b0100, 4'hF,    1'b1, 4'hF,
                {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110}};
    vecs[4] = '{16'h3210, 4'b1111, 4'b1010, 1'b1, 4'hF,
                {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}};
    vecs[5] = '{16'hFEDC, 4'b1111, 4'hF,    1'b0, 4'hF,
                {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110}};
    vecs[6] = '{16'h3210, 4'b0010, 4'hF,    1'b1, 4'h3,
                {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}};
    vecs[7] = '{16'h7654, 4'b0000, 4'b0110, 1'b1, 4'h0,
                {7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001}};

    apply(vecs[0]);
    rst_i = 1'b1;
    repeat (3) drive(1'b1);
    chk("reset_digit", int'(digit_o), 0);
    chk("reset_frame", int'(frame_o), 0);

    // Table-driven frames; the scoreboard checks every cycle.
    for (int v = 0; v < 8; v++) begin
      apply(vecs[v]);
      repeat (FRAME) drive(1'b0);
    end

    // enb dropped mid-slot: blank on the next output update, scan keeps counting.
    apply(vecs[0]);
    repeat (5) drive(1'b0);
    enb_i = 1'b0;
    drive(1'b0);
    chk("enb_off_an", int'(an_o), 15);
    chk("enb_off_seg", int'(seg_o), 127);
    repeat (20) drive(1'b0);
    enb_i = 1'b1;

    // Mid-slot reset during digit 2's 7th cycle.
    k = 0;
    while ((n % FRAME) != 2 * SLOT + 6 && k < 2 * FRAME) begin
      drive(1'b0);
      k++;
    end
    chk("reach_digit2_c7", int'(digit_o), 2);
    drive(1'b1);
    chk("midrst_an", int'(an_o), 15);
    chk("midrst_digit", int'(digit_o), 0);
    k = 0;
    while (digit_o == 2'd0 && k < 40) begin
      drive(1'b0);
      k++;
    end
    chk("midrst_slot_len", k, SLOT);
    repeat (FRAME + 4) drive(1'b0);

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
